// File: rtl/bpu_update_queue.sv
// rtl/bpu_update_queue.sv - FWFT queue scheduling dual-slot EX branch resolutions onto one predictor update port
// Optional macro BPU_UPD_MISPRED_PRIO_EN: a mistaken request wins the last free slot.
module bpu_update_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ex_a_valid,
  input  logic [31:0]                ex_a_pc,
  input  logic                       ex_a_taken,
  input  logic [31:0]                ex_a_target,
  input  logic                       ex_a_mistaken,
  input  logic                       ex_b_valid,
  input  logic [31:0]                ex_b_pc,
  input  logic                       ex_b_taken,
  input  logic [31:0]                ex_b_target,
  input  logic                       ex_b_mistaken,
  output logic                       upd_valid,
  output logic [31:0]                upd_pc,
  output logic                       upd_taken,
  output logic [31:0]                upd_target,
  output logic                       upd_mistaken,
  input  logic                       upd_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] FREE_ONE = (CW+1)'(1);
  localparam logic [CW:0] FREE_TWO = (CW+1)'(2);
  localparam logic [CW:0] DEPTH_W  = (CW+1)'(DEPTH);

  logic [31:0]   pc_mem     [DEPTH];
  logic          taken_mem  [DEPTH];
  logic [31:0]   target_mem [DEPTH];
  logic          mis_mem    [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] b_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  logic          req_a;
  logic          req_b;
  logic          pop;
  logic [CW:0]   free;
  logic          push_a;
  logic          push_b;
  logic          drop;

  // b is on the flushed wrong path when an older a mispredicts
  assign req_a = ex_a_valid;
  assign req_b = ex_b_valid & ~(ex_a_valid & ex_a_mistaken);
  assign pop   = upd_valid & upd_ready;
  assign free  = DEPTH_W - {1'b0, count_q} + {{CW{1'b0}}, pop};

  always_comb begin
    push_a = 1'b0;
    push_b = 1'b0;
    drop   = 1'b0;
    if (free >= FREE_TWO) begin
      push_a = req_a;
      push_b = req_b;
    end else if (free == FREE_ONE) begin
`ifdef BPU_UPD_MISPRED_PRIO_EN
      if (req_a && req_b && ex_b_mistaken) begin
        push_b = 1'b1;
        drop   = 1'b1;
      end else if (req_a) begin
        push_a = 1'b1;
        drop   = req_b;
      end else begin
        push_b = req_b;
      end
`else
      if (req_a) begin
        push_a = 1'b1;
        drop   = req_b;
      end else begin
        push_b = req_b;
      end
`endif
    end else begin
      drop = req_a | req_b;
    end
  end

  // b lands behind a when both are pushed, otherwise takes the tail slot itself
  assign b_ptr = wr_ptr + PW'(push_a);

  always_ff @(posedge clk) begin
    if (push_a) begin
      pc_mem[wr_ptr]     <= ex_a_pc;
      taken_mem[wr_ptr]  <= ex_a_taken;
      target_mem[wr_ptr] <= ex_a_target;
      mis_mem[wr_ptr]    <= ex_a_mistaken;
    end
    if (push_b) begin
      pc_mem[b_ptr]      <= ex_b_pc;
      taken_mem[b_ptr]   <= ex_b_taken;
      target_mem[b_ptr]  <= ex_b_target;
      mis_mem[b_ptr]     <= ex_b_mistaken;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + PW'(push_a) + PW'(push_b);
      rd_ptr     <= rd_ptr + PW'(pop);
      count_q    <= count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
      overflow_q <= drop;
    end
  end

  // Head fields are gated so an empty queue presents all-zero outputs
  assign upd_valid    = (count_q != '0);
  assign upd_pc       = upd_valid ? pc_mem[rd_ptr]     : '0;
  assign upd_taken    = upd_valid ? taken_mem[rd_ptr]  : 1'b0;
  assign upd_target   = upd_valid ? target_mem[rd_ptr] : '0;
  assign upd_mistaken = upd_valid ? mis_mem[rd_ptr]    : 1'b0;
  assign count        = count_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_bpu_update_queue.sv
// tb/tb_bpu_update_queue.sv - table-driven self-checking bench for bpu_update_queue
module tb_bpu_update_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_a_valid = 0, ex_a_taken = 0, ex_a_mistaken = 0;
  logic [31:0] ex_a_pc = '0, ex_a_target = '0;
  logic        ex_b_valid = 0, ex_b_taken = 0, ex_b_mistaken = 0;
  logic [31:0] ex_b_pc = '0, ex_b_target = '0;
  logic        upd_valid, upd_taken, upd_mistaken, upd_ready = 0;
  logic [31:0] upd_pc, upd_target;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  bpu_update_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .ex_a_valid(ex_a_valid), .ex_a_pc(ex_a_pc), .ex_a_taken(ex_a_taken),
    .ex_a_target(ex_a_target), .ex_a_mistaken(ex_a_mistaken),
    .ex_b_valid(ex_b_valid), .ex_b_pc(ex_b_pc), .ex_b_taken(ex_b_taken),
    .ex_b_target(ex_b_target), .ex_b_mistaken(ex_b_mistaken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mistaken(upd_mistaken), .upd_ready(upd_ready),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [31:0] apc;
    logic        amis;
    logic        bv;
    logic [31:0] bpc;
    logic        bmis;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_taken;
    logic        e_mis;
    logic [2:0]  e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic av, logic [31:0] apc, logic amis,
                              logic bv, logic [31:0] bpc, logic bmis, logic rdy,
                              logic ev, logic [31:0] epc, logic etk, logic emis,
                              logic [2:0] ecnt, logic eovf);
    vec_t v;
    v.av = av; v.apc = apc; v.amis = amis;
    v.bv = bv; v.bpc = bpc; v.bmis = bmis; v.rdy = rdy;
    v.e_valid = ev; v.e_pc = epc; v.e_taken = etk; v.e_mis = emis;
    v.e_cnt = ecnt; v.e_ovf = eovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // a slots are always taken, b slots not taken; target is pc + 0x100
  task automatic drive(input logic av, input logic [31:0] apc, input logic amis,
                       input logic bv, input logic [31:0] bpc, input logic bmis,
                       input logic rdy);
    ex_a_valid = av; ex_a_pc = apc; ex_a_taken = 1'b1;
    ex_a_target = apc + 32'h100; ex_a_mistaken = amis;
    ex_b_valid = bv; ex_b_pc = bpc; ex_b_taken = 1'b0;
    ex_b_target = bpc + 32'h100; ex_b_mistaken = bmis;
    upd_ready = rdy;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc,
                         input logic etk, input logic emis, input logic [2:0] ecnt,
                         input logic eovf);
    chk({tag, " upd_valid"},    32'(upd_valid),    32'(ev));
    chk({tag, " upd_pc"},       upd_pc,            epc);
    chk({tag, " upd_target"},   upd_target,        ev ? epc + 32'h100 : 32'h0);
    chk({tag, " upd_taken"},    32'(upd_taken),    32'(etk));
    chk({tag, " upd_mistaken"}, 32'(upd_mistaken), 32'(emis));
    chk({tag, " count"},        32'(count),        32'(ecnt));
    chk({tag, " overflow"},     32'(overflow),     32'(eovf));
  endtask

  initial begin
    vecs[0]  = mk(1, 32'h1c000100, 0, 0, 32'h0, 0, 1,  1, 32'h1c000100, 1, 0, 3'd1, 0);
    vecs[1]  = mk(0, 32'h0, 0, 0, 32'h0, 0, 1,         0, 32'h0, 0, 0, 3'd0, 0);
    vecs[2]  = mk(1, 32'h10000000, 0, 1, 32'h10000010, 0, 0, 1, 32'h10000000, 1, 0, 3'd2, 0);
    vecs[3]  = mk(1, 32'h10000020, 0, 1, 32'h10000030, 0, 0, 1, 32'h10000000, 1, 0, 3'd4, 0);
    vecs[4]  = mk(1, 32'h10000040, 0, 1, 32'h10000050, 0, 0, 1, 32'h10000000, 1, 0, 3'd4, 1);
    vecs[5]  = mk(0, 32'h0, 0, 0, 32'h0, 0, 1,         1, 32'h10000010, 0, 0, 3'd3, 0);
    vecs[6]  = mk(0, 32'h0, 0, 0, 32'h0, 0, 1,         1, 32'h10000020, 1, 0, 3'd2, 0);
    vecs[7]  = mk(0, 32'h0, 0, 0, 32'h0, 0, 1,         1, 32'h10000030, 0, 0, 3'd1, 0);
    vecs[8]  = mk(0, 32'h0, 0, 0, 32'h0, 0, 1,         0, 32'h0, 0, 0, 3'd0, 0);
    vecs[9]  = mk(1, 32'h10000060, 1, 1, 32'h10000070, 0, 0, 1, 32'h10000060, 1, 1, 3'd1, 0);
    vecs[10] = mk(1, 32'h10000080, 0, 1, 32'h10000090, 0, 0, 1, 32'h10000060, 1, 1, 3'd3, 0);
    vecs[11] = mk(1, 32'h100000a0, 0, 1, 32'h100000b0, 0, 1, 1, 32'h10000080, 1, 0, 3'd4, 0);
    vecs[12] = mk(1, 32'h100000c0, 0, 1, 32'h100000d0, 1, 1, 1, 32'h10000090, 0, 0, 3'd4, 1);
    vecs[13] = mk(0, 32'h0, 0, 0, 32'h0, 0, 1,         1, 32'h100000a0, 1, 0, 3'd3, 0);
    vecs[14] = mk(0, 32'h0, 0, 0, 32'h0, 0, 1,         1, 32'h100000b0, 0, 0, 3'd2, 0);
`ifdef BPU_UPD_MISPRED_PRIO_EN
    vecs[15] = mk(0, 32'h0, 0, 0, 32'h0, 0, 1,         1, 32'h100000d0, 0, 1, 3'd1, 0);
`else
    vecs[15] = mk(0, 32'h0, 0, 0, 32'h0, 0, 1,         1, 32'h100000c0, 1, 0, 3'd1, 0);
`endif
    vecs[16] = mk(0, 32'h0, 0, 0, 32'h0, 0, 1,         0, 32'h0, 0, 0, 3'd0, 0);

    #12;
    chk_out("reset", 0, 32'h0, 0, 0, 3'd0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].av, vecs[i].apc, vecs[i].amis, vecs[i].bv, vecs[i].bpc,
            vecs[i].bmis, vecs[i].rdy);
      @(posedge clk);
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_taken,
              vecs[i].e_mis, vecs[i].e_cnt, vecs[i].e_ovf);
    end

    // fill to three entries, then reset between edges
    drive(1, 32'h20000000, 0, 1, 32'h20000010, 0, 0);
    @(posedge clk); #1;
    drive(1, 32'h20000020, 0, 0, 32'h0, 0, 0);
    @(posedge clk); #1;
    chk("pre_reset count", 32'(count), 32'd3);
    drive(0, 32'h0, 0, 0, 32'h0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_reset", 0, 32'h0, 0, 0, 3'd0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 32'h30000000, 0, 0, 32'h0, 0, 0);
    @(posedge clk); #1;
    chk_out("post_reset", 1, 32'h30000000, 1, 0, 3'd1, 0);
    drive(0, 32'h0, 0, 0, 32'h0, 0, 1);
    @(posedge clk); #1;
    chk_out("post_reset_drain", 0, 32'h0, 0, 0, 3'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
